multicycle_control_unit: RTL and testbench

//  Multi-cycle MIPS control FSM; successor to the single-cycle opcode decoder. Sequences each

---
 rtl/mcu_pkg.sv | 45 ++++
 rtl/mcu_if.sv | 33 +++
 rtl/mcu_output_decode.sv | 55 +++++
 rtl/multicycle_control_unit.sv | 66 ++++++
 tb/tb_multicycle_control_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mcu_pkg.sv
// mcu_pkg: shared types and codes for the multi-cycle MIPS control unit
package mcu_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_MEM_WB,
    S_EXEC, S_R_WB, S_ADDI_EX, S_ADDI_WB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;
  function automatic state_t dispatch(logic [5:0] op, logic en_addi, logic en_jump);
    return op == OP_RTYPE ? S_EXEC :
           (op == OP_LW || op == OP_SW) ? S_MEM_ADDR :
           op == OP_BEQ ? S_BRANCH :
           (op == OP_ADDI && en_addi) ? S_ADDI_EX :
           (op == OP_J && en_jump) ? S_JUMP : S_TRAP;
  endfunction
endpackage

// File: rtl/mcu_if.sv
// mcu_if: control unit <-> datapath signal bundle
interface mcu_if #(parameter int CNT_W = 16);
  logic [5:0]       instr_op;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;
  modport master (
    input  instr_op, zero, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, instr_count
  );
  modport slave (
    output instr_op, zero, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, instr_count
  );
endinterface

// File: rtl/mcu_output_decode.sv
// mcu_output_decode: state (+ effective mem_ready) to datapath control vector
module mcu_output_decode import mcu_pkg::*; (
  input  state_t state,
  input  logic   rdy,
  output ctrl_t  ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = rdy;
        ctrl.pc_write  = rdy;
        ctrl.alu_src_b = SRCB_FOUR;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR, S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_ADDI_WB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer with stall, trap and retire count
module multicycle_control_unit import mcu_pkg::*; #(
  parameter int CNT_W    = 16,
  parameter bit EN_ADDI  = 1'b1,
  parameter bit EN_JUMP  = 1'b1,
  parameter bit MEM_WAIT = 1'b1
) (
  input logic  clk,
  input logic  rst_n,
  mcu_if.master bus
);
  state_t           state, state_nx;
  ctrl_t            ctrl;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] count;
  logic             illegal;
  logic             rdy;
  logic             retire;
  assign rdy = MEM_WAIT ? bus.mem_ready : 1'b1;
  // MEM_ADDR steers on the opcode captured in DECODE, not the live bus
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     state_nx = S_FETCH;
      S_FETCH:    state_nx = rdy ? S_DECODE : S_FETCH;
      S_DECODE:   state_nx = dispatch(bus.instr_op, EN_ADDI, EN_JUMP);
      S_MEM_ADDR: state_nx = op_q == OP_SW ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_nx = rdy ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_nx = rdy ? S_FETCH : S_MEM_WR;
      S_EXEC:     state_nx = S_R_WB;
      S_ADDI_EX:  state_nx = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: state_nx = S_FETCH;
      default:    state_nx = state;
    endcase
  end
  assign retire = state != S_IDLE && state != S_FETCH && state_nx == S_FETCH;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= '0;
      count   <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) op_q <= bus.instr_op;
      if (retire) count <= count + 1'b1;
      if (state_nx == S_TRAP) illegal <= 1'b1;
    end
  end
  mcu_output_decode u_dec (.state(state), .rdy(rdy), .ctrl(ctrl));
  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.illegal_op    = illegal;
  assign bus.instr_count   = count;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: three configurations checked every cycle against an instruction-level model
module tb_multicycle_control_unit;
  localparam int CW [3] = '{16, 4, 8};
  localparam int EA [3] = '{1, 1, 0};
  localparam int EJ [3] = '{1, 1, 0};
  localparam int MW [3] = '{1, 1, 0};
  localparam logic [5:0] OPS [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_ILL = 6;
  typedef struct { bit idle; bit trap; int kind; int k; int cnt; bit ill; } mdl_t;
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b1;
  logic [5:0] op = '0;
  int checks = 0, failures = 0;
  mdl_t m [3];
  logic [15:0] act_w [3];
  int act_c [3];
  logic act_i [3];
  always #5 clk = ~clk;
  mcu_if #(.CNT_W(16)) b0 ();
  mcu_if #(.CNT_W(4))  b1 ();
  mcu_if #(.CNT_W(8))  b2 ();
  multicycle_control_unit #(.CNT_W(16)) d0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  multicycle_control_unit #(.CNT_W(4))  d1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  multicycle_control_unit #(.CNT_W(8), .EN_ADDI(1'b0), .EN_JUMP(1'b0), .MEM_WAIT(1'b0)) d2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  assign b0.instr_op = op;  assign b0.zero = zero; assign b0.mem_ready = mem_ready;
  assign b1.instr_op = op;  assign b1.zero = zero; assign b1.mem_ready = mem_ready;
  assign b2.instr_op = op;  assign b2.zero = zero; assign b2.mem_ready = mem_ready;
  assign act_w[0] = {b0.pc_write, b0.pc_write_cond, b0.i_or_d, b0.mem_read, b0.mem_write, b0.ir_write,
                     b0.mem_to_reg, b0.reg_dst, b0.reg_write, b0.alu_src_a, b0.alu_src_b, b0.alu_op, b0.pc_source};
  assign act_w[1] = {b1.pc_write, b1.pc_write_cond, b1.i_or_d, b1.mem_read, b1.mem_write, b1.ir_write,
                     b1.mem_to_reg, b1.reg_dst, b1.reg_write, b1.alu_src_a, b1.alu_src_b, b1.alu_op, b1.pc_source};
  assign act_w[2] = {b2.pc_write, b2.pc_write_cond, b2.i_or_d, b2.mem_read, b2.mem_write, b2.ir_write,
                     b2.mem_to_reg, b2.reg_dst, b2.reg_write, b2.alu_src_a, b2.alu_src_b, b2.alu_op, b2.pc_source};
  assign act_c[0] = int'(b0.instr_count);
  assign act_c[1] = int'(b1.instr_count);
  assign act_c[2] = int'(b2.instr_count);
  assign act_i[0] = b0.illegal_op;
  assign act_i[1] = b1.illegal_op;
  assign act_i[2] = b2.illegal_op;
  function automatic logic [15:0] cv(input bit pcw, pcc, iod, mr, mw, irw, m2r, rd, rw, asa,
                                     input logic [1:0] asb, aop, ps);
    return {pcw, pcc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps};
  endfunction
  function automatic mdl_t mreset();
    mdl_t r;
    r.idle = 1; r.trap = 0; r.kind = 0; r.k = 0; r.cnt = 0; r.ill = 0;
    return r;
  endfunction
  function automatic int kind_of(logic [5:0] o, int ea, int ej);
    if (o == 6'b000000) return K_R;
    if (o == 6'b100011) return K_LW;
    if (o == 6'b101011) return K_SW;
    if (o == 6'b000100) return K_BEQ;
    if (o == 6'b001000 && ea != 0) return K_ADDI;
    if (o == 6'b000010 && ej != 0) return K_J;
    return K_ILL;
  endfunction
  function automatic int last_step(int kd);
    return (kd == K_LW) ? 4 : (kd == K_BEQ || kd == K_J) ? 2 : 3;
  endfunction
  // step 0 is instruction fetch, step 1 register decode, later steps depend on the instruction
  function automatic logic [15:0] expw(mdl_t s, bit r);
    logic [15:0] addr = cv(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
    if (s.idle || s.trap) return '0;
    if (s.k == 0) return cv(r,0,0,1,0,r,0,0,0,0,2'b01,2'b00,2'b00);
    if (s.k == 1) return cv(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00);
    case (s.kind)
      K_R:    return s.k == 2 ? cv(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00) : cv(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00);
      K_LW:   return s.k == 2 ? addr : s.k == 3 ? cv(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00) : cv(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00);
      K_SW:   return s.k == 2 ? addr : cv(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00);
      K_BEQ:  return cv(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01);
      K_ADDI: return s.k == 2 ? addr : cv(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00);
      K_J:    return cv(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10);
      default: return '0;
    endcase
  endfunction
  task automatic lchk(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, a, e, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) m[i] = mreset();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        bit r;
        logic [15:0] e;
        r = (MW[i] != 0) ? mem_ready : 1'b1;
        if (!rst_n) m[i] = mreset();
        e = expw(m[i], r);
        checks += 3;
        if (act_w[i] !== e) begin
          failures++;
          $display("FAIL dut%0d ctrl act=%h exp=%h t=%0t", i, act_w[i], e, $time);
        end
        if (act_c[i] != m[i].cnt) begin
          failures++;
          $display("FAIL dut%0d count act=%0d exp=%0d t=%0t", i, act_c[i], m[i].cnt, $time);
        end
        if (act_i[i] !== m[i].ill) begin
          failures++;
          $display("FAIL dut%0d illegal act=%0b exp=%0b t=%0t", i, act_i[i], m[i].ill, $time);
        end
        if (rst_n) begin
          if (m[i].idle) begin
            m[i].idle = 0; m[i].k = 0;
          end else if (!m[i].trap) begin
            if (m[i].k == 0) begin
              if (r) m[i].k = 1;
            end else if (m[i].k == 1) begin
              m[i].kind = kind_of(op, EA[i], EJ[i]);
              if (m[i].kind == K_ILL) begin
                m[i].trap = 1; m[i].ill = 1;
              end else m[i].k = 2;
            end else if (m[i].k == 3 && (m[i].kind == K_LW || m[i].kind == K_SW) && !r) begin
            end else if (m[i].k == last_step(m[i].kind)) begin
              m[i].k = 0;
              m[i].cnt = (m[i].cnt + 1) % (1 << CW[i]);
            end else m[i].k++;
          end
        end
      end
    end
  end
  initial begin
    repeat (3) tick();
    lchk("rst_ctrl", int'(act_w[0]), 0);
    lchk("rst_cnt", act_c[0], 0);
    rst_n = 1'b1;
    repeat (4) tick();
    lchk("r_wb", int'({b0.reg_dst, b0.reg_write}), 3);
    tick();
    lchk("r_count", act_c[0], 1);
    op = 6'b100011;
    repeat (2) tick();
    op = 6'b101011;
    tick();
    mem_ready = 1'b0;
    lchk("lw_rd0", int'({b0.mem_read, b0.i_or_d}), 3);
    tick();
    lchk("lw_rd1", int'({b0.mem_read, b0.i_or_d}), 3);
    tick();
    lchk("lw_rd2", int'({b0.mem_read, b0.i_or_d}), 3);
    mem_ready = 1'b1;
    repeat (2) tick();
    lchk("lw_count", act_c[0], 2);
    lchk("lw_fetch", int'(b0.mem_read), 1);
    op = 6'b000100;
    zero = 1'b1;
    repeat (2) tick();
    lchk("beq_ctrl", int'({b0.pc_write_cond, b0.pc_source, b0.alu_op}), 5'b1_01_01);
    tick();
    lchk("beq_count", act_c[0], 3);
    rst_n = 1'b0;
    zero = 1'b0;
    tick();
    rst_n = 1'b1;
    op = 6'b000010;
    repeat (3) tick();
    lchk("trap_ill", int'(act_i[2]), 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      lchk("trap_hold", int'({act_i[2], act_w[2]}), 32'h10000);
    end
    repeat (26) tick();
    lchk("wrap_zero", act_c[1], 0);
    repeat (3) tick();
    lchk("wrap_one", act_c[1], 1);
    lchk("j17_count", act_c[0], 17);
    op = 6'b101011;
    repeat (3) tick();
    mem_ready = 1'b0;
    tick();
    lchk("sw_hold", int'(b0.mem_write), 1);
    #2 rst_n = 1'b0;
    #1;
    lchk("sw_abort", int'(b0.mem_write), 0);
    lchk("sw_abort_cnt", act_c[0], 0);
    mem_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    lchk("restart_fetch", int'({b0.mem_read, b0.ir_write}), 3);
    for (int i = 0; i < 3000; i++) begin
      tick();
      op = ($urandom % 8 == 0) ? 6'($urandom) : OPS[$urandom % 6];
      mem_ready = ($urandom % 4) != 0;
      zero = 1'($urandom);
      rst_n = ($urandom % 400) != 0;
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
